// File: rtl/lbr_pkg.sv
// rtl/lbr_pkg.sv - shared encodings for the LBR controller slice
package lbr_pkg;

  // Request opcodes carried by memory-stage LBR instructions
  typedef enum logic [1:0] {
    LBR_REQ_NONE  = 2'b00,
    LBR_REQ_READ  = 2'b01,
    LBR_REQ_CLEAR = 2'b10,
    LBR_REQ_DUMP  = 2'b11
  } lbr_req_e;

  // Request engine states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_DUMP = 2'b10
  } lbr_state_e;

  // Entry packing: {from PC, to PC}; "to" occupies the low half
  localparam int LBR_ENTRY_TO_LSB   = 0;
  localparam int LBR_ENTRY_FROM_LSB = 32;

endpackage

// File: rtl/lbr_controller_if.sv
// rtl/lbr_controller_if.sv - valid/ready response channel of the LBR controller
interface lbr_controller_if #(
  parameter int LBR_DATA_WIDTH = 64
);
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [LBR_DATA_WIDTH-1:0] rsp_data;
  logic                      rsp_last;
  logic                      rsp_error;

  modport master (output rsp_valid, rsp_data, rsp_last, rsp_error, input rsp_ready);
  modport slave  (input rsp_valid, rsp_data, rsp_last, rsp_error, output rsp_ready);
endinterface

// File: rtl/lbr_ring_mem.sv
// rtl/lbr_ring_mem.sv - LBR entry storage, one write port, one registered read port
module lbr_ring_mem #(
  parameter int LBR_DATA_WIDTH = 64,
  parameter int LBR_SIZE       = 16,
  parameter int LBR_INDEX_BITS = 4
) (
  input  logic                      clock,
  input  logic                      we,
  input  logic [LBR_INDEX_BITS-1:0] waddr,
  input  logic [LBR_DATA_WIDTH-1:0] wdata,
  input  logic                      re,
  input  logic [LBR_INDEX_BITS-1:0] raddr,
  output logic [LBR_DATA_WIDTH-1:0] rdata
);
  logic [LBR_DATA_WIDTH-1:0] mem [LBR_SIZE];

  // Write the entry; read is write-first so a request can see a branch captured in the same cycle
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/lbr_controller.sv
// rtl/lbr_controller.sv - LBR ring sequencer; optional drop counter via LBR_DROP_COUNT_EN
module lbr_controller import lbr_pkg::*; #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int LBR_DATA_WIDTH = 64,
  parameter int LBR_SIZE       = 16,
  parameter int LBR_INDEX_BITS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [1:0]                next_PC_sel,
  input  logic [DATA_WIDTH-1:0]     PC_address,
  input  logic [DATA_WIDTH-1:0]     target_address,
  input  logic [1:0]                lbr_req,
  input  logic [LBR_INDEX_BITS-1:0] req_index,
  output logic                      busy,
  lbr_controller_if.master          rsp,
  output logic [LBR_INDEX_BITS:0]   lbr_count,
  output logic [15:0]               dropped
);
  localparam int IB = LBR_INDEX_BITS;
  localparam logic [IB:0] FULL = (IB+1)'(LBR_SIZE);

  lbr_state_e          state;
  logic [IB-1:0]       wr_ptr, rec_ptr, raddr;
  logic [IB:0]         count, rec_count, beat, beat_next;
  logic                rsp_valid_q, rsp_last_q, rsp_error_q;
  logic                taken, req_ok, do_clear, do_rec, re, hs, read_err;
  logic [LBR_DATA_WIDTH-1:0] rdata;
  lbr_req_e            req;

  assign req       = lbr_req_e'(lbr_req);
  assign taken     = (next_PC_sel != 2'b00);
  assign req_ok    = (state == ST_IDLE) && !stall;
  assign do_clear  = req_ok && (req == LBR_REQ_CLEAR);
  assign do_rec    = req_ok && taken && !do_clear;
  // Buffer view including a branch recorded this cycle, so a coincident request sees it
  assign rec_ptr   = do_rec ? wr_ptr + 1'b1 : wr_ptr;
  assign rec_count = (do_rec && count != FULL) ? count + 1'b1 : count;
  assign read_err  = ({1'b0, req_index} >= rec_count);
  assign hs        = rsp_valid_q && rsp.rsp_ready;
  assign beat_next = beat + 1'b1;

  // Ring read address: logical index i maps to (wr_ptr - 1 - i)
  always_comb begin
    re    = 1'b0;
    raddr = rec_ptr - 1'b1;
    case (state)
      ST_IDLE: begin
        if (req_ok && req == LBR_REQ_READ) begin
          re    = 1'b1;
          raddr = rec_ptr - 1'b1 - req_index;
        end else if (req_ok && req == LBR_REQ_DUMP) begin
          re    = 1'b1;
        end
      end
      ST_DUMP: begin
        if (hs && !rsp_last_q) begin
          re    = 1'b1;
          raddr = wr_ptr - 1'b1 - beat_next[IB-1:0];
        end
      end
      default: ;
    endcase
  end

  lbr_ring_mem #(
    .LBR_DATA_WIDTH (LBR_DATA_WIDTH),
    .LBR_SIZE       (LBR_SIZE),
    .LBR_INDEX_BITS (LBR_INDEX_BITS)
  ) u_ring (
    .clock (clock),
    .we    (do_rec),
    .waddr (wr_ptr),
    .wdata ({PC_address, target_address}),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Pointer/count bookkeeping and request FSM with registered response flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      count       <= '0;
      beat        <= '0;
      busy        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      if (do_rec) begin
        wr_ptr <= rec_ptr;
        count  <= rec_count;
      end
      case (state)
        ST_IDLE: begin
          if (req_ok) begin
            case (req)
              LBR_REQ_READ: begin
                state       <= ST_READ;
                busy        <= 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_last_q  <= 1'b1;
                rsp_error_q <= read_err;
              end
              LBR_REQ_DUMP: begin
                state       <= ST_DUMP;
                busy        <= 1'b1;
                rsp_valid_q <= 1'b1;
                beat        <= '0;
                rsp_last_q  <= (rec_count <= 1);
                rsp_error_q <= (rec_count == '0);
              end
              LBR_REQ_CLEAR: begin
                wr_ptr <= '0;
                count  <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_READ, ST_DUMP: begin
          if (hs) begin
            if (rsp_last_q) begin
              state       <= ST_IDLE;
              busy        <= 1'b0;
              rsp_valid_q <= 1'b0;
              rsp_last_q  <= 1'b0;
              rsp_error_q <= 1'b0;
            end else begin
              beat       <= beat_next;
              rsp_last_q <= (beat_next == count - 1'b1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp.rsp_valid = rsp_valid_q;
  assign rsp.rsp_last  = rsp_last_q;
  assign rsp.rsp_error = rsp_error_q;
  assign rsp.rsp_data  = (rsp_valid_q && !rsp_error_q) ? rdata : '0;
  assign lbr_count     = count;

`ifdef LBR_DROP_COUNT_EN
  logic        drop_now;
  logic [15:0] drop_cnt;

  // A live taken branch is lost while busy or when it collides with a clear
  assign drop_now = !stall && taken && ((state != ST_IDLE) || do_clear);

  // Saturating drop counter; a clear restarts it, still counting its own collision
  always_ff @(posedge clock) begin
    if (reset)
      drop_cnt <= '0;
    else if (do_clear)
      drop_cnt <= {15'b0, drop_now};
    else if (drop_now && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign dropped = drop_cnt;
`else
  assign dropped = '0;
`endif
endmodule

// File: tb/tb_lbr_controller.sv
// tb/tb_lbr_controller.sv - scoreboard bench for lbr_controller
module tb_lbr_controller;
  import lbr_pkg::*;

  localparam int DW = 32;
  localparam int LW = 64;
  localparam int SZ = 16;
  localparam int IB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall;
  logic [1:0]    next_PC_sel;
  logic [DW-1:0] PC_address, target_address;
  logic [1:0]    lbr_req;
  logic [IB-1:0] req_index;
  logic          busy;
  logic [IB:0]   lbr_count;
  logic [15:0]   dropped;

  lbr_controller_if #(.LBR_DATA_WIDTH(LW)) rsp_if ();

  lbr_controller #(
    .CORE(0), .DATA_WIDTH(DW), .LBR_DATA_WIDTH(LW), .LBR_SIZE(SZ), .LBR_INDEX_BITS(IB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .next_PC_sel    (next_PC_sel),
    .PC_address     (PC_address),
    .target_address (target_address),
    .lbr_req        (lbr_req),
    .req_index      (req_index),
    .busy           (busy),
    .rsp            (rsp_if),
    .lbr_count      (lbr_count),
    .dropped        (dropped)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [LW-1:0] data;
    logic          last;
    logic          err;
  } beat_t;

  beat_t       sb[$];
  beat_t       held;
  bit          held_v = 0;
  bit          mon_en = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;

  logic [LW-1:0] m_ring [SZ];
  int          m_ptr = 0;
  int          m_count = 0;
  int          m_drop = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_drop();
`ifdef LBR_DROP_COUNT_EN
    return (m_drop > 16'hFFFF) ? 16'hFFFF : 16'(m_drop);
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [LW-1:0] m_entry(input int i);
    return m_ring[(m_ptr - 1 - i + 2*SZ) % SZ];
  endfunction

  // Response monitor: hold stability and in-order scoreboard compare
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (held_v) begin
        check("hold_valid", LW'(rsp_if.rsp_valid), LW'(1));
        check("hold_data", rsp_if.rsp_data, held.data);
        check("hold_last", LW'(rsp_if.rsp_last), LW'(held.last));
      end
      held_v = rsp_if.rsp_valid && !rsp_if.rsp_ready;
      held   = '{rsp_if.rsp_data, rsp_if.rsp_last, rsp_if.rsp_error};
      if (rsp_if.rsp_valid && rsp_if.rsp_ready) begin
        beat_t e;
        hs_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_beat", LW'(sb.size()), LW'(1));
        end else begin
          e = sb.pop_front();
          check("beat_data", rsp_if.rsp_data, e.data);
          check("beat_last", LW'(rsp_if.rsp_last), LW'(e.last));
          check("beat_error", LW'(rsp_if.rsp_error), LW'(e.err));
        end
      end
    end else begin
      held_v = 0;
    end
  end

  // One IDLE-state cycle of stimulus; the model tracks what the DUT should do with it
  task automatic cyc(input logic [1:0] sel, input logic [DW-1:0] pc, input logic [DW-1:0] tgt,
                     input logic [1:0] req, input int idx);
    next_PC_sel = sel; PC_address = pc; target_address = tgt;
    lbr_req = req; req_index = IB'(idx);
    if (req == LBR_REQ_CLEAR) begin
      m_ptr = 0; m_count = 0; m_drop = (sel != 2'b00) ? 1 : 0;
    end else if (sel != 2'b00) begin
      m_ring[m_ptr] = {pc, tgt};
      m_ptr = (m_ptr + 1) % SZ;
      if (m_count < SZ) m_count++;
    end
    if (req == LBR_REQ_READ) begin
      if (idx >= m_count) sb.push_back('{'0, 1'b1, 1'b1});
      else                sb.push_back('{m_entry(idx), 1'b1, 1'b0});
    end else if (req == LBR_REQ_DUMP) begin
      if (m_count == 0) sb.push_back('{'0, 1'b1, 1'b1});
      else for (int i = 0; i < m_count; i++) sb.push_back('{m_entry(i), (i == m_count-1), 1'b0});
    end
    @(posedge clock); #1;
    next_PC_sel = 2'b00; lbr_req = LBR_REQ_NONE; req_index = '0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("drain_sb", LW'(sb.size()), LW'(0));
    check("drain_busy", LW'(busy), LW'(0));
  endtask

  initial begin
    int start;
    reset = 1'b1; stall = 1'b0; next_PC_sel = '0; PC_address = '0; target_address = '0;
    lbr_req = '0; req_index = '0; rsp_if.rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_valid", LW'(rsp_if.rsp_valid), LW'(0));
    check("rst_busy", LW'(busy), LW'(0));
    check("rst_count", LW'(lbr_count), LW'(0));
    check("rst_data", rsp_if.rsp_data, LW'(0));
    check("rst_last_err", LW'({rsp_if.rsp_last, rsp_if.rsp_error}), LW'(0));
    check("rst_dropped", LW'(dropped), LW'(0));
    @(posedge clock); #1;
    reset = 1'b0; mon_en = 1;

    // Three branches then reads: newest, out of range, oldest, index == count
    cyc(2'b01, 32'h100, 32'h200, LBR_REQ_NONE, 0);
    cyc(2'b10, 32'h104, 32'h300, LBR_REQ_NONE, 0);
    cyc(2'b11, 32'h108, 32'h400, LBR_REQ_NONE, 0);
    check("count3", LW'(lbr_count), LW'(3));
    cyc(2'b00, 0, 0, LBR_REQ_READ, 0);
    check("read_lat_valid", LW'(rsp_if.rsp_valid), LW'(1));
    check("read_lat_busy", LW'(busy), LW'(1));
    check("read0_data", rsp_if.rsp_data, {32'h108, 32'h400});
    wait_drain(20);
    cyc(2'b00, 0, 0, LBR_REQ_READ, 5);
    wait_drain(20);
    cyc(2'b00, 0, 0, LBR_REQ_READ, 2);
    wait_drain(20);
    cyc(2'b00, 0, 0, LBR_REQ_READ, 3);
    wait_drain(20);
    check("count3_after", LW'(lbr_count), LW'(3));

    // Stalled branch and request are both ignored
    stall = 1'b1; next_PC_sel = 2'b01; lbr_req = LBR_REQ_READ;
    @(posedge clock); #1;
    stall = 1'b0; next_PC_sel = 2'b00; lbr_req = LBR_REQ_NONE;
    @(negedge clock);
    check("stall_count", LW'(lbr_count), LW'(3));
    check("stall_busy", LW'(busy), LW'(0));

    // Branch coincident with read: read sees the new entry
    cyc(2'b01, 32'h10C, 32'h500, LBR_REQ_READ, 0);
    wait_drain(20);
    check("count4", LW'(lbr_count), LW'(4));

    // Clear with a coincident branch, then dump of an empty buffer
    cyc(2'b01, 32'hDEAD, 32'hBEEF, LBR_REQ_CLEAR, 0);
    check("clear_count", LW'(lbr_count), LW'(0));
    check("clear_dropped", LW'(dropped), LW'(exp_drop()));
    cyc(2'b00, 0, 0, LBR_REQ_DUMP, 0);
    wait_drain(20);

    // Twenty branches wrap the ring; full dump with ready held high
    for (int i = 0; i < 20; i++) cyc(2'b01, 32'h1000 + 32'(4*i), 32'h8000 + 32'(i), LBR_REQ_NONE, 0);
    check("count_full", LW'(lbr_count), LW'(SZ));
    start = hs_cnt;
    cyc(2'b00, 0, 0, LBR_REQ_DUMP, 0);
    wait_drain(40);
    check("dump_beats", LW'(hs_cnt - start), LW'(SZ));

    // Dump with random backpressure; every branch while busy must be dropped
    cyc(2'b00, 0, 0, LBR_REQ_DUMP, 0);
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      rsp_if.rsp_ready = 1'($urandom_range(0, 1));
      next_PC_sel = 2'b01; PC_address = 32'hF000 + 32'(k); target_address = 32'hE000;
      m_drop++;
      @(posedge clock); #1;
    end
    next_PC_sel = 2'b00; rsp_if.rsp_ready = 1'b1;
    wait_drain(40);
    check("bp_count", LW'(lbr_count), LW'(SZ));
    check("bp_dropped", LW'(dropped), LW'(exp_drop()));
    cyc(2'b00, 0, 0, LBR_REQ_DUMP, 0);
    wait_drain(40);

    // Reset in the middle of a dump aborts the response
    start = hs_cnt;
    cyc(2'b00, 0, 0, LBR_REQ_DUMP, 0);
    for (int k = 0; k < 50 && hs_cnt < start + 3; k++) @(negedge clock);
    mon_en = 0; reset = 1'b1; sb.delete();
    @(negedge clock);
    check("abort_valid", LW'(rsp_if.rsp_valid), LW'(0));
    check("abort_busy", LW'(busy), LW'(0));
    check("abort_count", LW'(lbr_count), LW'(0));
    check("abort_dropped", LW'(dropped), LW'(0));
    @(posedge clock); #1;
    reset = 1'b0; m_ptr = 0; m_count = 0; m_drop = 0; mon_en = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("post_reset_valid", LW'(rsp_if.rsp_valid), LW'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
